// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The caller owns start/op/operands/cancel; the unit owns status and HI/LO.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO; MT* take one edge, mul/div hold busy MUL_LAT/DIV_LAT cycles.
// No backpressure: start is ignored while busy, so the caller stalls on busy; cancel aborts and leaves HI/LO intact.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  muldiv_unit_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic             issue, fin, ld;

  assign issue = bus.start && !bus.cancel && (state_q == IDLE);
  assign fin   = !bus.cancel && (state_q != IDLE) && (cnt_q == '0);
  assign ld    = issue && !bus.op[2];

  // Datapath works only on the latched operands, so the caller may reuse a/b.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, quo_mag, rem_mag, quo, rem;

  always_comb begin
    ext_a    = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b    = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod     = ext_a * ext_b;
    a_neg    = sgn_q & a_q[WIDTH-1];
    b_neg    = sgn_q & b_q[WIDTH-1];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    div_zero = (b_q == '0);
    // Keep the divider defined for b=0; that result is overridden anyway.
    b_safe   = div_zero ? WIDTH'(1) : b_mag;
    quo_mag  = a_mag / b_safe;
    rem_mag  = a_mag % b_safe;
    quo      = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    rem      = a_neg ? -rem_mag : rem_mag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                state_d = MUL;
                cnt_d   = CW'(MUL_LAT - 1);
              end
              OP_DIV, OP_DIVU: begin
                state_d = DIV;
                cnt_d   = CW'(DIV_LAT - 1);
              end
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    dbz_d  = dbz_q;
    done_d = fin;
    busy_d = (state_d != IDLE);
    if (issue && bus.op == OP_MTHI) hi_d = bus.a;
    if (issue && bus.op == OP_MTLO) lo_d = bus.a;
    if (fin) begin
      if (state_q == MUL) begin
        {hi_d, lo_d} = prod;
      end else if (div_zero) begin
        hi_d  = a_q;
        lo_d  = '1;
        dbz_d = 1'b1;
      end else begin
        hi_d  = rem;
        lo_d  = quo;
        dbz_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
      if (ld) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        sgn_q <= ~bus.op[0];
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: results modelled at issue, checked on done.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  res_t        sb[$];
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dbz = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic dbz_prev);
    res_t        r;
    longint      p;
    logic [63:0] up;
    int          sa, sd;
    r.hi  = exp_hi;
    r.lo  = exp_lo;
    r.dbz = dbz_prev;
    case (op)
      3'b000: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {r.hi, r.lo} = p;
      end
      3'b001: begin
        up = {32'b0, a} * {32'b0, b};
        {r.hi, r.lo} = up;
      end
      default: begin
        if (b == 32'd0) begin
          r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
        end else begin
          r.dbz = 1'b0;
          if (op == 3'b011) begin
            r.lo = a / b; r.hi = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.lo = 32'h8000_0000; r.hi = 32'd0;
          end else begin
            sa = a; sd = b;
            r.lo = sa / sd; r.hi = sa % sd;
          end
        end
      end
    endcase
    return r;
  endfunction

  // Compares every completion against the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    res_t e;
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hi", 64'(bus.hi), 64'(e.hi));
        chk("lo", 64'(bus.lo), 64'(e.lo));
        chk("dbz", 64'(bus.div_by_zero), 64'(e.dbz));
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
    res_t r;
    int   n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    r = model(op, a, b, exp_dbz);
    sb.push_back(r);
    exp_hi = r.hi; exp_lo = r.lo; exp_dbz = r.dbz;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b110; bus.a = $urandom; bus.b = $urandom;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", 64'(n), 64'(lat));
    chk("done_seen", 64'(bus.done), 64'd1);
    @(negedge clk);
    chk("done_pulse", 64'(bus.done), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.op = 3'b110; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 5);
    chk("t1_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    chk("t1_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFA);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    chk("t2_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    chk("t2_lo_const", 64'(bus.lo), 64'h0000_0000_0000_0001);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 10);
    chk("t3_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    chk("t3_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    run_op(3'b011, 32'd7, 32'd0, 10);
    chk("t3_dbz_const", 64'(bus.div_by_zero), 64'd1);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("t4_lo_const", 64'(bus.lo), 64'h0000_0000_8000_0000);
    run_op(3'b011, 32'd9, 32'd4, 10);
    chk("t4_dbz_const", 64'(bus.div_by_zero), 64'd0);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 50)));
      if (i == 5) ra = -32'sd100;
      run_op(rop, ra, rb, rop[1] ? 10 : 5);
    end

    // Cancel mid-DIV, with an ignored MTHI issued while busy.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_busy", 64'(bus.busy), 64'd0);
    chk("cancel_hi", 64'(bus.hi), 64'(exp_hi));
    chk("cancel_lo", 64'(bus.lo), 64'(exp_lo));
    chk("cancel_done", 64'(bus.done), 64'd0);
    repeat (12) @(negedge clk);
    chk("cancel_quiet_hi", 64'(bus.hi), 64'(exp_hi));

    // Cancel beats start in IDLE.
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd4; bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("cancel_idle_busy", 64'(bus.busy), 64'd0);
    repeat (6) @(negedge clk);
    chk("cancel_idle_lo", 64'(bus.lo), 64'(exp_lo));

    // Asynchronous reset mid-MULT.
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_hi", 64'(bus.hi), 64'd0);
    chk("arst_lo", 64'(bus.lo), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_dbz", 64'(bus.div_by_zero), 64'd0);
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (7) @(negedge clk);
    chk("arst_no_done_hi", 64'(bus.hi), 64'd0);

    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mthi_hi", 64'(bus.hi), 64'h1234);
    chk("mthi_lo", 64'(bus.lo), 64'd0);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_done", 64'(bus.done), 64'd0);
    bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mtlo_lo", 64'(bus.lo), 64'h5678);
    chk("mtlo_hi", 64'(bus.hi), 64'h1234);
    repeat (3) @(negedge clk);
    chk("sb_left", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
